// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the wave-RAM blocks: default address/data widths,
// the maximum channel count, counter width, the reset value of the
// round-robin pointer, and a one-hot to binary helper used by the wave_ram
// users.
//
// Configuration macro: WAVE_RD_ARB_PRIO_EN
//   defined   : ch0 has strict priority and the round-robin pointer lives in
//               1..NUM_CH-1, so it resets to 1.
//   undefined : pure round-robin, pointer resets to 0.
// ---------------------------------------------------------------------------
package wave_pkg;

  localparam int WAVE_AWIDTH = 8;
  localparam int WAVE_DWIDTH = 16;
  localparam int WAVE_MAX_CH = 8;
  localparam int WAVE_CH_W   = $clog2(WAVE_MAX_CH);
  localparam int WAVE_CNT_W  = 16;

`ifdef WAVE_RD_ARB_PRIO_EN
  localparam logic [WAVE_CH_W-1:0] WAVE_RR_PTR_RST = WAVE_CH_W'(1);
`else
  localparam logic [WAVE_CH_W-1:0] WAVE_RR_PTR_RST = '0;
`endif

  // OR-reduction encoder: valid only for one-hot or all-zero inputs, which is
  // all the arbiter ever produces. Cheaper than a priority encoder.
  function automatic logic [WAVE_CH_W-1:0] onehot2bin(input logic [WAVE_MAX_CH-1:0] oh);
    logic [WAVE_CH_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < WAVE_MAX_CH; i++) begin
      if (oh[i]) bin = bin | WAVE_CH_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wave_rd_arb_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin grant plus next-pointer logic for wave_rd_arb.
// The grant is taken from the requests at or above the pointer; if there are
// none, the lowest request overall wins (wrap-around).
//
// Configuration macro: WAVE_RD_ARB_PRIO_EN (ch0 strict priority, ch1..N-1
// round-robin, pointer wraps to 1 and is not moved by ch0 grants).
//
// Ports
//   en_i     in  1        grant enable (already gated by reset in the parent)
//   req_i    in  NUM_CH   per-channel request
//   ptr_i    in  3        current round-robin pointer
//   gnt_o    out NUM_CH   one-hot grant, subset of req_i, 0 when en_i=0
//   ptr_d_o  out 3        pointer value after this cycle's grant (holds if none)
// ---------------------------------------------------------------------------
module rr_arb
  import wave_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                 en_i,
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [WAVE_CH_W-1:0] ptr_i,
  output logic [NUM_CH-1:0]    gnt_o,
  output logic [WAVE_CH_W-1:0] ptr_d_o
);

  localparam logic [WAVE_CH_W-1:0] LAST_CH = WAVE_CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]    rr_req;
  logic [NUM_CH-1:0]    rr_mask;
  logic [NUM_CH-1:0]    rr_hit;
  logic [NUM_CH-1:0]    pick;
  logic [WAVE_CH_W-1:0] gnt_idx;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    rr_req = req_i;
`ifdef WAVE_RD_ARB_PRIO_EN
    rr_req[0] = 1'b0;
`endif
    // Keep only channels at or above the pointer; x & -x isolates the lowest set bit.
    rr_mask = ~((NUM_CH'(1) << ptr_i) - NUM_CH'(1));
    rr_hit  = rr_req & rr_mask;
    if (|rr_hit) pick = rr_hit & (~rr_hit + NUM_CH'(1));
    else         pick = rr_req & (~rr_req + NUM_CH'(1));
`ifdef WAVE_RD_ARB_PRIO_EN
    if (req_i[0]) pick = NUM_CH'(1);
`endif
    gnt_o = en_i ? pick : '0;
  end

  always_comb begin
    gnt_idx = onehot2bin(WAVE_MAX_CH'(gnt_o));
    ptr_d_o = ptr_i;
    if (|gnt_o) begin
`ifdef WAVE_RD_ARB_PRIO_EN
      if (!gnt_o[0]) ptr_d_o = (gnt_idx == LAST_CH) ? WAVE_CH_W'(1) : gnt_idx + WAVE_CH_W'(1);
`else
      ptr_d_o = (gnt_idx == LAST_CH) ? '0 : gnt_idx + WAVE_CH_W'(1);
`endif
    end
  end

endmodule

// File: rtl/wave_rd_arb.sv
// ---------------------------------------------------------------------------
// wave_rd_arb
// Shares the single wave-RAM read port among NUM_CH playback channels.
// A transfer happens when req[i] && gnt[i] at a rising rclk edge; the next
// cycle carries ram_re/ram_raddr, and RAM_LAT cycles later the returning
// ram_rdata is tagged with rd_v (one-hot channel). Per-channel saturating
// grant counters are readable through cnt_sel/grant_cnt.
//
// Configuration macro: WAVE_RD_ARB_PRIO_EN (ch0 strict priority).
//
// Ports
//   rclk, r_rst         clock; asynchronous active-high reset
//   enable              0 blocks new grants, in-flight reads still complete
//   req, req_addr       per-channel request and address (ch i at [i*AWIDTH +: AWIDTH])
//   gnt                 one-hot combinational ready
//   ram_re, ram_raddr   registered RAM read strobe/address
//   ram_rdata           RAM read data
//   rd_v, rd_data       one-hot data-valid tag, data passed straight through
//   cnt_clr             synchronous clear of all grant counters
//   cnt_sel, grant_cnt  counter select and registered counter view
// ---------------------------------------------------------------------------
module wave_rd_arb
  import wave_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int AWIDTH  = WAVE_AWIDTH,
  parameter int DWIDTH  = WAVE_DWIDTH,
  parameter int RAM_LAT = 1
) (
  input  logic                     rclk,
  input  logic                     r_rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*AWIDTH-1:0] req_addr,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     ram_re,
  output logic [AWIDTH-1:0]        ram_raddr,
  input  logic [DWIDTH-1:0]        ram_rdata,
  output logic [NUM_CH-1:0]        rd_v,
  output logic [DWIDTH-1:0]        rd_data,
  input  logic                     cnt_clr,
  input  logic [2:0]               cnt_sel,
  output logic [WAVE_CNT_W-1:0]    grant_cnt
);

  logic                  arb_en;
  logic [WAVE_CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [AWIDTH-1:0]     ram_raddr_q, addr_d;
  logic [WAVE_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [WAVE_CNT_W-1:0] cnt_q [NUM_CH];
  // Stage 0 is the cycle ram_re is high; stage RAM_LAT is the cycle data returns.
  logic [NUM_CH-1:0]     tag_q [RAM_LAT+1];

  // gnt must stay low during reset even though the asynchronous state is cleared.
  assign arb_en = enable & ~r_rst;

  rr_arb #(.NUM_CH(NUM_CH)) u_rr_arb (
    .en_i    (arb_en),
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .ptr_d_o (rr_ptr_d)
  );

  // gnt is one-hot and a subset of req, so an AND-OR mux picks the granted address.
  always_comb begin
    addr_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) addr_d = addr_d | req_addr[i*AWIDTH +: AWIDTH];
    end
  end

  // Unimplemented selects (>= NUM_CH) fall through to zero.
  always_comb begin
    grant_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == 3'(i)) grant_cnt_d = cnt_q[i];
    end
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      // NOTE: the tag pipe and counters are a handful of flops, not RAM, so resetting them is cheap and discards in-flight reads.
      rr_ptr_q    <= WAVE_RR_PTR_RST;
      ram_raddr_q <= '0;
      grant_cnt_q <= '0;
      for (int j = 0; j <= RAM_LAT; j++) tag_q[j] <= '0;
      for (int i = 0; i < NUM_CH; i++)   cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
      if (|gnt) ram_raddr_q <= addr_d;
      tag_q[0] <= gnt;
      for (int j = 1; j <= RAM_LAT; j++) tag_q[j] <= tag_q[j-1];
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_clr)                      cnt_q[i] <= '0;
        else if (gnt[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + WAVE_CNT_W'(1);
      end
    end
  end

  assign ram_re    = |tag_q[0];
  assign ram_raddr = ram_raddr_q;
  assign rd_v      = tag_q[RAM_LAT];
  assign rd_data   = ram_rdata;
  assign grant_cnt = grant_cnt_q;

endmodule
